// File: rtl/vadd_result_checker.sv
// vadd_result_checker
// Self-checking consumer for the 4-lane pipelined vector adder. Recomputes the
// lane sums from the adder operands, delays them by the adder latency, compares
// them with the adder outputs after a post-reset warm-up window, counts
// mismatching lanes and raises a sticky pass/fail verdict after NUM_CHECKS
// counted comparisons.
// Optional feature: define VADD_CHK_FIRST_ERR_EN to capture the mismatch mask
// and the expected/actual values of the lowest failing lane on the first
// failing comparison. Without it those outputs are tied to zero.
module vadd_result_checker #(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 2,
    parameter int WARMUP     = 4995,
    parameter int NUM_CHECKS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] b_0,
    input  logic [WIDTH-1:0] b_1,
    input  logic [WIDTH-1:0] b_2,
    input  logic [WIDTH-1:0] b_3,
    input  logic [WIDTH-1:0] y_0,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    input  logic [WIDTH-1:0] y_3,
    output logic [31:0]      check_count,
    output logic [15:0]      err_count,
    output logic             done,
    output logic             pass,
    output logic [3:0]       first_err_mask,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act
);

    typedef enum logic [1:0] {
        S_WARMUP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [31:0]      warm_count;
    logic             armed;
    logic [WIDTH-1:0] exp_in [4];
    logic [WIDTH-1:0] act    [4];
    logic             dly_en  [LATENCY];
    logic [WIDTH-1:0] dly_exp [LATENCY][4];
    logic [3:0]       mism;
    logic [2:0]       miss_n;
    logic             qualify;
    logic             last_check;
    logic             warm_end;
    logic [15:0]      err_next;

    // Saturating add of a lane-mismatch count onto the 16-bit error counter.
    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {14'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Expected lane sums (carry discarded) and adder outputs as lane arrays.
    always_comb begin
        exp_in[0] = a_0 + b_0;
        exp_in[1] = a_1 + b_1;
        exp_in[2] = a_2 + b_2;
        exp_in[3] = a_3 + b_3;
        act[0]    = y_0;
        act[1]    = y_1;
        act[2]    = y_2;
        act[3]    = y_3;
    end

    // Delay line matching the adder latency; shifts every cycle, cleared in reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                dly_en[s] <= 1'b0;
                for (int l = 0; l < 4; l++) dly_exp[s][l] <= '0;
            end
        end else begin
            dly_en[0] <= en;
            for (int l = 0; l < 4; l++) dly_exp[0][l] <= exp_in[l];
            for (int s = 1; s < LATENCY; s++) begin
                dly_en[s] <= dly_en[s-1];
                for (int l = 0; l < 4; l++) dly_exp[s][l] <= dly_exp[s-1][l];
            end
        end
    end

    // Per-lane mismatch mask at the delay-line tail and its population count.
    always_comb begin
        mism   = 4'b0000;
        miss_n = 3'd0;
        for (int l = 0; l < 4; l++) begin
            mism[l] = (dly_exp[LATENCY-1][l] != act[l]);
            miss_n  = miss_n + {2'b00, mism[l]};
        end
    end

    // The first CHECK cycle coincides with the warm-up hand-over and is skipped
    // via armed, so counting begins on the cycle after it.
    assign qualify    = dly_en[LATENCY-1] && (state == S_CHECK) && armed;
    assign last_check = (check_count == 32'(NUM_CHECKS - 1));
    assign warm_end   = (warm_count == 32'(WARMUP - 1));
    assign err_next   = sat_add(err_count, miss_n);
    assign done       = (state == S_DONE);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) state <= S_WARMUP;
        else        state <= next_state;
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_WARMUP: if (warm_end) next_state = S_CHECK;
            S_CHECK:  if (qualify && last_check) next_state = S_DONE;
            S_DONE:   next_state = S_DONE;
            default:  next_state = S_WARMUP;
        endcase
    end

    // Warm-up cycle counter and the flag that marks CHECK as past its first cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            warm_count <= 32'd0;
            armed      <= 1'b0;
        end else begin
            if (state == S_WARMUP && !warm_end) warm_count <= warm_count + 32'd1;
            armed <= (state == S_CHECK);
        end
    end

    // Comparison counters and verdict; they only move on qualified compares.
    always_ff @(posedge clock) begin
        if (!reset) begin
            check_count <= 32'd0;
            err_count   <= 16'd0;
            pass        <= 1'b0;
        end else if (qualify) begin
            check_count <= check_count + 32'd1;
            err_count   <= err_next;
            if (last_check) pass <= (err_next == 16'd0);
        end
    end

`ifdef VADD_CHK_FIRST_ERR_EN
    logic             captured;
    logic [WIDTH-1:0] low_exp;
    logic [WIDTH-1:0] low_act;

    // Select the lowest-numbered failing lane; scanning downwards lets it win.
    always_comb begin
        low_exp = '0;
        low_act = '0;
        for (int l = 3; l >= 0; l--) begin
            if (mism[l]) begin
                low_exp = dly_exp[LATENCY-1][l];
                low_act = act[l];
            end
        end
    end

    // Latch the first failing qualified compare and hold it until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            captured       <= 1'b0;
            first_err_mask <= 4'b0000;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (qualify && (mism != 4'b0000) && !captured) begin
            captured       <= 1'b1;
            first_err_mask <= mism;
            first_err_exp  <= low_exp;
            first_err_act  <= low_act;
        end
    end
`else
    assign first_err_mask = 4'b0000;
    assign first_err_exp  = '0;
    assign first_err_act  = '0;
`endif

endmodule

// File: tb/tb_vadd_result_checker.sv
// Testbench for vadd_result_checker: table of full-run scenarios driven through
// a bench-side adder model, plus hand-written sequences for mid-CHECK reset and
// error-counter saturation on a second instance with NUM_CHECKS=20000.
module tb_vadd_result_checker;

    typedef struct {
        int         lat;         // latency of the bench adder model
        int         force_lane;  // lane whose output is forced to 6, -1 for none
        bit         toggle_en;   // en = 1,0,1,0,... instead of constant 1
        bit         vary;        // operands change every cycle
        int         exp_done;    // cycle after release at which done is first seen
        int         exp_chk;
        int         exp_err;
        bit         exp_pass;
        logic [3:0] exp_mask;
        logic [7:0] exp_fe;
        logic [7:0] exp_fa;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        en;
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [7:0]  y [4];
    logic [31:0] check_count;
    logic [15:0] err_count;
    logic        done;
    logic        pass;
    logic [3:0]  first_err_mask;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_act;

    logic        reset2;
    logic        en2;
    logic [7:0]  zero8;
    logic [7:0]  ones8;
    logic [31:0] check_count2;
    logic [15:0] err_count2;
    logic        done2;
    logic        pass2;
    logic [3:0]  first_err_mask2;
    logic [7:0]  first_err_exp2;
    logic [7:0]  first_err_act2;

    logic [7:0]  base_a [4];
    logic [7:0]  base_b [4];
    logic [7:0]  hist [64][4];

    int checks = 0;
    int errors = 0;

    vadd_result_checker #(.WIDTH(8), .LATENCY(2), .WARMUP(10), .NUM_CHECKS(4)) dut (
        .clock(clock), .reset(reset), .en(en),
        .a_0(a[0]), .a_1(a[1]), .a_2(a[2]), .a_3(a[3]),
        .b_0(b[0]), .b_1(b[1]), .b_2(b[2]), .b_3(b[3]),
        .y_0(y[0]), .y_1(y[1]), .y_2(y[2]), .y_3(y[3]),
        .check_count(check_count), .err_count(err_count),
        .done(done), .pass(pass),
        .first_err_mask(first_err_mask), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
    );

    vadd_result_checker #(.WIDTH(8), .LATENCY(2), .WARMUP(10), .NUM_CHECKS(20000)) dut_sat (
        .clock(clock), .reset(reset2), .en(en2),
        .a_0(zero8), .a_1(zero8), .a_2(zero8), .a_3(zero8),
        .b_0(zero8), .b_1(zero8), .b_2(zero8), .b_3(zero8),
        .y_0(ones8), .y_1(ones8), .y_2(ones8), .y_3(ones8),
        .check_count(check_count2), .err_count(err_count2),
        .done(done2), .pass(pass2),
        .first_err_mask(first_err_mask2), .first_err_exp(first_err_exp2),
        .first_err_act(first_err_act2)
    );

    task automatic check(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Present the operands of cycle n and the model adder output for that cycle.
    task automatic drive_cycle(input int n, input vec_t v);
        for (int i = 0; i < 4; i++) begin
            if (v.vary) begin
                a[i] = 8'(n + i);
                b[i] = 8'd0;
            end else begin
                a[i] = base_a[i];
                b[i] = base_b[i];
            end
            hist[n % 64][i] = a[i] + b[i];
            y[i] = (n - v.lat >= 1) ? hist[(n - v.lat) % 64][i] : 8'd0;
            if (v.force_lane == i) y[i] = 8'd6;
        end
        en = v.toggle_en ? n[0] : 1'b1;
    endtask

    task automatic hold_reset(input string tag);
        reset = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'd0; b[i] = 8'd0; y[i] = 8'd0;
        end
        repeat (3) @(posedge clock);
        #1;
        check({tag, " rst check_count"}, check_count, 0);
        check({tag, " rst err_count"}, err_count, 0);
        check({tag, " rst done"}, done, 0);
        check({tag, " rst pass"}, pass, 0);
        check({tag, " rst first_err_mask"}, first_err_mask, 0);
        check({tag, " rst first_err_exp"}, first_err_exp, 0);
        check({tag, " rst first_err_act"}, first_err_act, 0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int         done_at;
        string      tag;
        logic [3:0] m;
        logic [7:0] fe;
        logic [7:0] fa;
        tag = $sformatf("v%0d", idx);
        hold_reset(tag);
        reset   = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            drive_cycle(n, v);
            @(posedge clock);
            #1;
            if (done && done_at == 0) done_at = n;
        end
        m  = v.exp_mask;
        fe = v.exp_fe;
        fa = v.exp_fa;
`ifndef VADD_CHK_FIRST_ERR_EN
        m  = 4'b0000;
        fe = 8'd0;
        fa = 8'd0;
`endif
        check({tag, " done_cycle"}, done_at, v.exp_done);
        check({tag, " check_count"}, check_count, v.exp_chk);
        check({tag, " err_count"}, err_count, v.exp_err);
        check({tag, " pass"}, pass, v.exp_pass);
        check({tag, " first_err_mask"}, first_err_mask, m);
        check({tag, " first_err_exp"}, first_err_exp, fe);
        check({tag, " first_err_act"}, first_err_act, fa);
    endtask

    initial begin
        vec_t vecs [4];
        vec_t ideal;
        int   done_at;

        base_a = '{8'd0, 8'd3, 8'd2, 8'd1};
        base_b = '{8'hFE, 8'd2, 8'd4, 8'd8};
        zero8  = 8'd0;
        ones8  = 8'hFF;
        reset2 = 1'b0;
        en2    = 1'b1;
        reset  = 1'b0;
        en     = 1'b0;

        // Sums (254,5,6,9); first counted compare at cycle 12, done at 15.
        vecs[0] = '{lat: 2, force_lane: -1, toggle_en: 0, vary: 0, exp_done: 15,
                    exp_chk: 4, exp_err: 0, exp_pass: 1,
                    exp_mask: 4'b0000, exp_fe: 8'd0, exp_fa: 8'd0};
        // Lane 1 forced to 6 against expected 5: one error per compare.
        vecs[1] = '{lat: 2, force_lane: 1, toggle_en: 0, vary: 0, exp_done: 15,
                    exp_chk: 4, exp_err: 4, exp_pass: 0,
                    exp_mask: 4'b0010, exp_fe: 8'd5, exp_fa: 8'd6};
        // Model one cycle early with a_i = n+i: every lane off by one; first
        // compare at cycle 12 expects sum of cycle 10 (10) and sees cycle 11 (11).
        vecs[2] = '{lat: 1, force_lane: -1, toggle_en: 0, vary: 1, exp_done: 15,
                    exp_chk: 4, exp_err: 16, exp_pass: 0,
                    exp_mask: 4'b1111, exp_fe: 8'd10, exp_fa: 8'd11};
        // en high on odd cycles: counted compares at 13,15,17,19.
        vecs[3] = '{lat: 2, force_lane: -1, toggle_en: 1, vary: 0, exp_done: 19,
                    exp_chk: 4, exp_err: 0, exp_pass: 1,
                    exp_mask: 4'b0000, exp_fe: 8'd0, exp_fa: 8'd0};

        for (int k = 0; k < 4; k++) run_vector(vecs[k], k);

        // Reset pulse while in CHECK with two compares counted.
        ideal = vecs[0];
        hold_reset("mid");
        reset = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            drive_cycle(n, ideal);
            @(posedge clock);
            #1;
        end
        check("mid pre-reset check_count", check_count, 2);
        drive_cycle(14, ideal);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid after-pulse check_count", check_count, 0);
        check("mid after-pulse err_count", err_count, 0);
        check("mid after-pulse done", done, 0);
        check("mid after-pulse pass", pass, 0);
        reset   = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            drive_cycle(n, ideal);
            @(posedge clock);
            #1;
            if (n == 11) check("mid rewarm check_count@11", check_count, 0);
            if (n == 14) check("mid rewarm done@14", done, 0);
            if (done && done_at == 0) done_at = n;
        end
        check("mid rewarm done_cycle", done_at, 15);
        check("mid rewarm check_count", check_count, 4);
        check("mid rewarm pass", pass, 1);

        // Saturation: four errors per compare; 16383 compares give 65532 and the
        // next one clips to 65535. Compares are counted from cycle 12 onward.
        @(negedge clock);
        reset2  = 1'b1;
        done_at = 0;
        for (int n = 1; n <= 20100; n++) begin
            @(posedge clock);
            #1;
            if (n == 16394) check("sat err_count@16383", err_count2, 65532);
            if (n == 16395) check("sat err_count@16384", err_count2, 65535);
            if (done2 && done_at == 0) done_at = n;
        end
        check("sat done_cycle", done_at, 20011);
        check("sat check_count", check_count2, 20000);
        check("sat err_count", err_count2, 65535);
        check("sat pass", pass2, 0);
`ifdef VADD_CHK_FIRST_ERR_EN
        check("sat first_err_mask", first_err_mask2, 4'b1111);
        check("sat first_err_act", first_err_act2, 8'hFF);
`else
        check("sat first_err_mask", first_err_mask2, 0);
        check("sat first_err_act", first_err_act2, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
